// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for the SISC datapath: fetch/decode/execute/memory/writeback
// sequencing with opcode-dependent state skipping, memory handshake timeout, HALT and FAULT.
module sisc_ctrl_mc #(
    parameter int OPW          = 4,
    parameter int CCW          = 4,
    parameter int IMM_MM       = 8,
    parameter int MEM_TIMEOUT  = 15,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [CCW-1:0] mm,
    input  logic [CCW-1:0] stat,
    input  logic           mem_ack,
    input  logic           run,
    output logic           rf_we,
    output logic [1:0]     alu_op,
    output logic           wb_sel,
    output logic           rb_sel,
    output logic           pc_sel,
    output logic           pc_write,
    output logic           pc_rst,
    output logic           ir_load,
    output logic           br_sel,
    output logic           mem_re,
    output logic           mem_we,
    output logic           halted,
    output logic           fault,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        ST_START0    = 4'd0,
        ST_START1    = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7,
        ST_FAULT     = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_NOOP = OPW'(0);
    localparam logic [OPW-1:0] OP_LOD  = OPW'(1);
    localparam logic [OPW-1:0] OP_STR  = OPW'(2);
    localparam logic [OPW-1:0] OP_SWP  = OPW'(3);
    localparam logic [OPW-1:0] OP_BRA  = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(15);

    localparam logic [CCW-1:0] IMM_CODE = CCW'(IMM_MM);
    localparam logic [7:0]     TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;

    logic       is_branch;
    logic       is_legal;
    logic       is_mem_op;
    logic       cond_hit;
    logic       taken;
    logic       imm_mode;
    logic [1:0] alu_code;

    assign is_branch = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                       (opcode == OP_BNE) || (opcode == OP_BNR);
    assign is_mem_op = (opcode == OP_LOD) || (opcode == OP_STR);
    assign is_legal  = is_branch || is_mem_op || (opcode == OP_NOOP) ||
                       (opcode == OP_SWP) || (opcode == OP_ALU) || (opcode == OP_HLT);

    // BRA/BRR branch on any selected flag set, BNE/BNR on none set.
    assign cond_hit  = |(stat & mm);
    assign taken     = ((opcode == OP_BRA) || (opcode == OP_BRR)) ? cond_hit : ~cond_hit;

    assign imm_mode  = (mm == IMM_CODE);
    assign alu_code  = {(opcode != OP_ALU), imm_mode};

    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= ST_START0;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts unacknowledged MEM cycles; any other state or an ack restarts it.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            wait_cnt <= '0;
        end else if ((state_q == ST_MEM) && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        alu_op   = 2'b00;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        br_sel   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;

        case (state_q)
            ST_START0: begin
                pc_rst  = 1'b1;
                state_d = ST_START1;
            end
            ST_START1: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_branch) begin
                    pc_sel   = 1'b1;
                    br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
                    pc_write = taken;
                    state_d  = ST_START1;
                end else if (opcode == OP_NOOP) begin
                    state_d = ST_START1;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (!is_legal) begin
                    state_d = (TRAP_ILLEGAL != 0) ? ST_FAULT : ST_START1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                rb_sel  = imm_mode;
                alu_op  = alu_code;
                state_d = is_mem_op ? ST_MEM : ST_WRITEBACK;
            end
            // An ack on the final allowed cycle still wins over the timeout.
            ST_MEM: begin
                rb_sel = imm_mode;
                alu_op = alu_code;
                mem_re = (opcode == OP_LOD);
                mem_we = (opcode == OP_STR);
                if (mem_ack) begin
                    state_d = (opcode == OP_LOD) ? ST_WRITEBACK : ST_START1;
                end else if (wait_cnt == TMO_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                wb_sel  = (opcode == OP_LOD);
                rb_sel  = imm_mode;
                alu_op  = alu_code;
                state_d = ST_START1;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_d = ST_START1;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = ST_START0;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Self-checking bench for sisc_ctrl_mc: instruction-level reference traces plus directed literal checks.
module tb_sisc_ctrl_mc;

    localparam int OPW    = 4;
    localparam int CCW    = 4;
    localparam int IMM_MM = 8;
    localparam int TMO    = 4;

    logic           clk = 1'b0;
    logic           rst_f;
    logic [OPW-1:0] opcode;
    logic [CCW-1:0] mm;
    logic [CCW-1:0] stat;
    logic           mem_ack;
    logic           run;

    logic       rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel;
    logic       mem_re, mem_we, halted, fault;
    logic [1:0] alu_op;
    logic [3:0] state;

    logic       b_rf_we, b_wb_sel, b_rb_sel, b_pc_sel, b_pc_write, b_pc_rst, b_ir_load, b_br_sel;
    logic       b_mem_re, b_mem_we, b_halted, b_fault;
    logic [1:0] b_alu_op;
    logic [3:0] b_state;

    typedef struct packed {
        logic [3:0] st;
        logic       rf_we;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       rb_sel;
        logic       pc_sel;
        logic       pc_write;
        logic       pc_rst;
        logic       ir_load;
        logic       br_sel;
        logic       mem_re;
        logic       mem_we;
        logic       halted;
        logic       fault;
    } obs_t;

    obs_t dut_obs;
    obs_t exp_cur;
    bit   exp_valid = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sisc_ctrl_mc #(
        .OPW(OPW), .CCW(CCW), .IMM_MM(IMM_MM), .MEM_TIMEOUT(TMO), .TRAP_ILLEGAL(1)
    ) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_ack(mem_ack), .run(run), .rf_we(rf_we), .alu_op(alu_op),
        .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel), .pc_write(pc_write),
        .pc_rst(pc_rst), .ir_load(ir_load), .br_sel(br_sel), .mem_re(mem_re),
        .mem_we(mem_we), .halted(halted), .fault(fault), .state(state)
    );

    sisc_ctrl_mc #(
        .OPW(OPW), .CCW(CCW), .IMM_MM(IMM_MM), .MEM_TIMEOUT(15), .TRAP_ILLEGAL(0)
    ) dut_notrap (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_ack(mem_ack), .run(run), .rf_we(b_rf_we), .alu_op(b_alu_op),
        .wb_sel(b_wb_sel), .rb_sel(b_rb_sel), .pc_sel(b_pc_sel), .pc_write(b_pc_write),
        .pc_rst(b_pc_rst), .ir_load(b_ir_load), .br_sel(b_br_sel), .mem_re(b_mem_re),
        .mem_we(b_mem_we), .halted(b_halted), .fault(b_fault), .state(b_state)
    );

    assign dut_obs = {state, rf_we, alu_op, wb_sel, rb_sel, pc_sel, pc_write,
                      pc_rst, ir_load, br_sel, mem_re, mem_we, halted, fault};

    // Output table for a given state and IR fields, straight from the control-line rules.
    function automatic obs_t model_out(input logic [3:0] st, input logic [3:0] op,
                                       input logic [3:0] m, input logic [3:0] s);
        obs_t o;
        bit   imm;
        bit   hit;
        int   code;
        o     = '0;
        o.st  = st;
        imm   = (m == 4'(IMM_MM));
        hit   = ((s & m) != 4'd0);
        code  = ((op == 4'd8) ? 0 : 2) + (imm ? 1 : 0);
        case (st)
            4'd0: o.pc_rst = 1'b1;
            4'd2: begin o.ir_load = 1'b1; o.pc_write = 1'b1; end
            4'd3: if (op >= 4'd4 && op <= 4'd7) begin
                o.pc_sel   = 1'b1;
                o.br_sel   = (op == 4'd4) || (op == 4'd6);
                o.pc_write = (op <= 4'd5) ? hit : !hit;
            end
            4'd4, 4'd5, 4'd6: begin
                o.rb_sel = imm;
                o.alu_op = 2'(code);
                o.mem_re = (st == 4'd5) && (op == 4'd1);
                o.mem_we = (st == 4'd5) && (op == 4'd2);
                o.rf_we  = (st == 4'd6);
                o.wb_sel = (st == 4'd6) && (op == 4'd1);
            end
            4'd7: o.halted = 1'b1;
            4'd8: o.fault  = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // One clock of stimulus; st is the state the DUT must occupy during this cycle.
    task automatic applyStimulus(input int st, input logic [3:0] op, input logic [3:0] m,
                                 input logic [3:0] s, input logic ack, input logic rn,
                                 input logic rs, input bit chk);
        @(posedge clk);
        #1;
        opcode    = op;
        mm        = m;
        stat      = s;
        mem_ack   = ack;
        run       = rn;
        rst_f     = rs;
        exp_cur   = model_out(4'(st), op, m, s);
        exp_valid = chk;
        cyc++;
    endtask

    task automatic stp(input int st, input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input logic ack, input logic rn, input logic rs);
        applyStimulus(st, op, m, s, ack, rn, rs, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            checkOutput($sformatf("cycle%0d_state%0d", cyc, exp_cur.st),
                        32'(dut_obs), 32'(exp_cur));
        end
    end

    // n cycles in START0, reset held for all but the last.
    task automatic do_reset_tail(input int n);
        for (int i = 0; i < n; i++) begin
            stp(0, rnd4(), rnd4(), rnd4(), rb(), rb(), (i < n - 1));
        end
    endtask

    task automatic do_fault();
        int n;
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            stp(8, rnd4(), rnd4(), rnd4(), rb(), rb(), (i == n - 1));
        end
        do_reset_tail($urandom_range(1, 2));
    endtask

    // Expected trace for one whole instruction, starting at START1.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] m, input int ack_at,
                            input int halt_hold, input int rst_at);
        stp(1, rnd4(), rnd4(), rnd4(), rb(), rb(), 1'b0);
        stp(2, rnd4(), rnd4(), rnd4(), rb(), rb(), 1'b0);
        stp(3, op, m, rnd4(), rb(), rb(), 1'b0);
        if (op == 4'd0 || (op >= 4'd4 && op <= 4'd7)) return;
        if (op == 4'd15) begin
            for (int h = 0; h < halt_hold; h++) stp(7, op, m, rnd4(), rb(), 1'b0, 1'b0);
            stp(7, op, m, rnd4(), rb(), 1'b1, 1'b0);
            return;
        end
        if (op >= 4'd9 && op <= 4'd14) begin
            do_fault();
            return;
        end
        stp(4, op, m, rnd4(), rb(), rb(), 1'b0);
        if (op == 4'd1 || op == 4'd2) begin
            for (int i = 0; i < TMO; i++) begin
                stp(5, op, m, rnd4(), (i == ack_at), rb(), (i == rst_at));
                if (i == rst_at) begin
                    do_reset_tail($urandom_range(1, 2));
                    return;
                end
                if (i == ack_at) begin
                    if (op == 4'd1) stp(6, op, m, rnd4(), rb(), rb(), 1'b0);
                    return;
                end
            end
            do_fault();
            return;
        end
        stp(6, op, m, rnd4(), rb(), rb(), 1'b0);
    endtask

    initial begin
        int r;
        rst_f   = 1'b1;
        opcode  = '0;
        mm      = '0;
        stat    = '0;
        mem_ack = 1'b0;
        run     = 1'b0;

        applyStimulus(0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        stp(0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_pc_rst", 32'(pc_rst), 32'd1);

        // ALU with immediate
        stp(1, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd8, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(4, 4'd8, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("alu_imm_exec_alu_op", 32'(alu_op), 32'd1);
        checkOutput("alu_imm_exec_rb_sel", 32'(rb_sel), 32'd1);
        checkOutput("alu_imm_exec_rf_we", 32'(rf_we), 32'd0);
        stp(6, 4'd8, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("alu_imm_wb_state", 32'(state), 32'd6);
        checkOutput("alu_imm_wb_rf_we", 32'(rf_we), 32'd1);
        checkOutput("alu_imm_wb_alu_op", 32'(alu_op), 32'd1);

        // BRR taken, then BNE not taken, same flags
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd5, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("brr_pc_sel", 32'(pc_sel), 32'd1);
        checkOutput("brr_pc_write", 32'(pc_write), 32'd1);
        checkOutput("brr_br_sel", 32'(br_sel), 32'd0);
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd6, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bne_pc_write", 32'(pc_write), 32'd0);
        checkOutput("bne_br_sel", 32'(br_sel), 32'd1);

        // LOD, ack on the fourth MEM cycle (w=3): 9 cycles from START1
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(4, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stp(5, 4'd1, 4'd0, 4'd0, (i == 3), 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("lod_mem_re_%0d", i), 32'(mem_re), 32'd1);
        end
        stp(6, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lod_wb_sel", 32'(wb_sel), 32'd1);
        checkOutput("lod_alu_op_hold", 32'(alu_op), 32'd2);

        // Reset during LOD MEM wait
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(4, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(5, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(5, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        stp(0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("rst_mem_re_drop", 32'(mem_re), 32'd0);
        checkOutput("rst_mem_state", 32'(state), 32'd0);
        stp(0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // STR timeout, sticky fault through run pulses
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(4, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TMO; i++) stp(5, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(8, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        stp(8, 4'd2, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("timeout_fault_sticky", 32'(fault), 32'd1);
        stp(8, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        do_reset_tail(1);

        // Illegal opcode 12: trap in one instance, NOOP in the other
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd12, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(8, 4'd12, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("notrap_state", 32'(b_state), 32'd1);
        checkOutput("notrap_fault", 32'(b_fault), 32'd0);
        stp(8, 4'd12, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        do_reset_tail(1);

        // HLT held 10 cycles, then run
        stp(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stp(3, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) stp(7, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("halt_held", 32'(halted), 32'd1);
        stp(7, 4'd15, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            if (r >= 9 && r <= 14 && $urandom_range(0, 3) != 0) r = 8;
            do_instr(4'(r), (rb() ? 4'd8 : rnd4()), $urandom_range(0, TMO),
                     $urandom_range(0, 3),
                     (($urandom_range(0, 9) == 0) ? $urandom_range(0, TMO - 1) : -1));
        end

        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
